// File: rtl/core_lsu_ctrl.sv
// Load/store unit controller: runs one req/gnt/rvalid memory transaction at a time,
// generates byte enables and lane-replicated store data, and right-aligns load data.
module core_lsu_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic [DATA_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  offset_q;
    logic        misaligned;
    logic        accept;
    logic [3:0]  be_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = lsu_addr_i[0];
                be_d       = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_d    = {2{lsu_wdata_i[15:0]}};
            end
            2'b10:   misaligned = (lsu_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // A request arriving in DONE still belongs to the completing instruction.
    assign accept           = (state_q == IDLE) && lsu_req_i && !misaligned;
    assign lsu_misaligned_o = (state_q == IDLE) && lsu_req_i && misaligned;
    assign lsu_stall_o      = accept || (state_q == WAIT_GNT) || (state_q == WAIT_RVALID);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept)        state_d = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i)    state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_req_o   <= 1'b0;
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_wdata_o <= '0;
            offset_q     <= 2'b00;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
        end else begin
            lsu_rvalid_o <= 1'b0;
            if (accept) begin
                data_req_o   <= 1'b1;
                data_addr_o  <= {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
                data_we_o    <= lsu_we_i;
                data_be_o    <= be_d;
                data_wdata_o <= wdata_d;
                offset_q     <= lsu_addr_i[1:0];
            end
            if (state_q == WAIT_GNT && data_gnt_i) begin
                data_req_o <= 1'b0;
            end
            // Stores complete through rvalid too but leave the last load result intact.
            if (state_q == WAIT_RVALID && data_rvalid_i) begin
                lsu_rvalid_o <= 1'b1;
                if (!data_we_o) begin
                    lsu_rdata_o <= data_rdata_i >> {offset_q, 3'b000};
                end
            end
        end
    end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl: vector table for single accesses plus
// hand-written sequences for back-to-back, spurious handshake and mid-transaction reset.
module tb_core_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_stall_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misaligned_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk_i = ~clk_i;

    core_lsu_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_stall_o      (lsu_stall_o),
        .lsu_rvalid_o     (lsu_rvalid_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          gnt_dly;
        int          rv_dly;
        logic        spur;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        int          stall;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; keep_req leaves lsu_req_i high after DONE.
    task automatic run_txn(input vec_t v, input bit keep_req);
        int  stall_cnt = 0;
        int  gnt_cnt   = 0;
        int  rv_cnt    = 0;
        int  reqs      = 0;
        bit  rv_phase  = 0;
        bit  gnt_given = 0;
        bit  done      = 0;
        lsu_req_i   = 1'b1;
        lsu_we_i    = v.we;
        lsu_size_i  = v.size;
        lsu_addr_i  = v.addr;
        lsu_wdata_i = v.wdata;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        if (v.mis) begin
            #1;
            check({v.name, "_misaligned"}, 32'(lsu_misaligned_o), 32'd1);
            check({v.name, "_stall"}, 32'(lsu_stall_o), 32'd0);
            @(negedge clk_i);
            lsu_req_i = 1'b0;
            #1;
            check({v.name, "_no_req"}, 32'(data_req_o), 32'd0);
            check({v.name, "_mis_clear"}, 32'(lsu_misaligned_o), 32'd0);
            @(negedge clk_i);
            return;
        end
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (gnt_given) begin
                rv_phase  = 1'b1;
                gnt_given = 1'b0;
            end
            if (rv_phase) begin
                if (rv_cnt == v.rv_dly) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = v.mem;
                    rv_phase      = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end
            if (data_req_o) begin
                check({v.name, "_addr"}, data_addr_o, v.addr & 32'hFFFF_FFFC);
                check({v.name, "_be"}, 32'(data_be_o), 32'(v.be));
                check({v.name, "_we"}, 32'(data_we_o), 32'(v.we));
                check({v.name, "_wdata"}, data_wdata_o, v.exp_wdata);
                if (gnt_cnt == v.gnt_dly) begin
                    data_gnt_i = 1'b1;
                    gnt_given  = 1'b1;
                    reqs++;
                end else begin
                    gnt_cnt++;
                    if (v.spur) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = 32'hDEAD_BEEF;
                    end
                end
            end
            #1;
            if (lsu_stall_o) stall_cnt++;
            if (lsu_rvalid_o) begin
                done = 1'b1;
                if (!v.we) last_rdata = v.rdata;
                check({v.name, "_rdata"}, lsu_rdata_o, last_rdata);
                check({v.name, "_done_stall"}, 32'(lsu_stall_o), 32'd0);
            end
            @(negedge clk_i);
        end
        check({v.name, "_completed"}, 32'(done), 32'd1);
        check({v.name, "_stall_cycles"}, 32'(stall_cnt), 32'(v.stall));
        check({v.name, "_num_reqs"}, 32'(reqs), 32'd1);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        if (!keep_req) begin
            lsu_req_i = 1'b0;
            #1;
            check({v.name, "_pulse_end"}, 32'(lsu_rvalid_o), 32'd0);
            @(negedge clk_i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t b0, b1, lh;
        //          name        we    size   addr        wdata         mem          g  r  spur  mis   be       exp_wdata     st rdata
        vecs[0] = '{"lb_1003",  1'b0, 2'b00, 32'h1003, 32'h0000_0000, 32'h80AA55CC, 0, 0, 1'b0, 1'b0, 4'b1000, 32'h0000_0000, 3, 32'h0000_0080};
        vecs[1] = '{"sh_2002",  1'b1, 2'b01, 32'h2002, 32'h0000_BEEF, 32'h0000_0000, 0, 2, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 5, 32'h0};
        vecs[2] = '{"lw_3001",  1'b0, 2'b10, 32'h3001, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         0, 32'h0};
        vecs[3] = '{"sz11_3000",1'b0, 2'b11, 32'h3000, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         0, 32'h0};
        vecs[4] = '{"lw_gnt3",  1'b0, 2'b10, 32'h4000, 32'h1234_5678, 32'hCAFE_F00D, 3, 0, 1'b1, 1'b0, 4'b1111, 32'h1234_5678, 6, 32'hCAFE_F00D};
        vecs[5] = '{"sb_5002",  1'b1, 2'b00, 32'h5002, 32'hFFFF_FF5A, 32'h0000_0000, 1, 1, 1'b0, 1'b0, 4'b0100, 32'h5A5A_5A5A, 5, 32'h0};
        vecs[6] = '{"lh_6002",  1'b0, 2'b01, 32'h6002, 32'h0000_0000, 32'hBEEF_0000, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0000_0000, 3, 32'h0000_BEEF};
        vecs[7] = '{"lh_6003",  1'b0, 2'b01, 32'h6003, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         0, 32'h0};
        vecs[8] = '{"sw_7000",  1'b1, 2'b10, 32'h7000, 32'h0102_0304, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0102_0304, 3, 32'h0};
        vecs[9] = '{"lb_8001",  1'b0, 2'b00, 32'h8001, 32'h0000_0077, 32'h0000_AB00, 0, 0, 1'b0, 1'b0, 4'b0010, 32'h7777_7777, 3, 32'h0000_00AB};
        b0      = '{"b2b_lw",   1'b0, 2'b10, 32'h0010, 32'h0000_0000, 32'h1122_3344, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 3, 32'h1122_3344};
        b1      = '{"b2b_sb",   1'b1, 2'b00, 32'h0015, 32'h0000_00A5, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 3, 32'h0};
        lh      = '{"lh_post",  1'b0, 2'b01, 32'h0042, 32'h0000_0000, 32'hDEAD_1234, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0000_0000, 3, 32'h0000_DEAD};

        rstn_i = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        #1;
        check("rst_req", 32'(data_req_o), 32'd0);
        check("rst_be", 32'(data_be_o), 32'd0);
        check("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
        check("rst_stall", 32'(lsu_stall_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Spurious gnt/rvalid while idle must not start or complete anything.
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("idle_spur_stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("idle_spur_req", 32'(data_req_o), 32'd0);
        check("idle_spur_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check("idle_spur_rdata", lsu_rdata_o, 32'h0);
        @(negedge clk_i);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], 1'b0);

        run_txn(b0, 1'b1);
        run_txn(b1, 1'b0);

        // Reset while an abandoned store waits for rvalid.
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b10;
        lsu_addr_i = 32'h0044; lsu_wdata_i = 32'h1111_1111;
        @(negedge clk_i);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        lsu_req_i  = 1'b0;
        rstn_i     = 1'b0;
        #1;
        check("mid_rst_req", 32'(data_req_o), 32'd0);
        check("mid_rst_we", 32'(data_we_o), 32'd0);
        check("mid_rst_be", 32'(data_be_o), 32'd0);
        check("mid_rst_addr", data_addr_o, 32'h0);
        check("mid_rst_wdata", data_wdata_o, 32'h0);
        check("mid_rst_rdata", lsu_rdata_o, 32'h0);
        check("mid_rst_stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h9999_9999;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        #1;
        check("late_rv_pulse", 32'(lsu_rvalid_o), 32'd0);
        check("late_rv_rdata", lsu_rdata_o, 32'h0);
        check("late_rv_req", 32'(data_req_o), 32'd0);
        @(negedge clk_i);
        last_rdata = 32'h0;
        run_txn(lh, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
